// File: rtl/onehot_decoder_scan.sv
// Registered 4-to-16 one-hot decoder with per-pattern hold timing and an auto-scan mode.
// Latency: pattern appears one edge after accept (or scan entry) and lasts HOLD_CYCLES cycles.
// Backpressure: in_ready is low whenever a pattern is active or scan mode is requested.
module onehot_decoder_scan #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  binary,
  output logic [15:0] onehot,
  output logic        busy,
  output logic [3:0]  scan_idx,
  output logic        scan_wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      onehot_n;
  logic [3:0]       idx_n;
  logic [3:0]       idx_inc;
  logic             wrap_n;
  logic             busy_n;

  // A code is only taken while idle and not asked to scan, so mode wins over in_valid.
  assign in_ready = (state == IDLE) && !mode;
  assign idx_inc  = scan_idx + 4'd1;

  // State register and registered outputs; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      onehot    <= '0;
      scan_idx  <= '0;
      scan_wrap <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      onehot    <= onehot_n;
      scan_idx  <= idx_n;
      scan_wrap <= wrap_n;
      busy      <= busy_n;
    end
  end

  // Next-state and next-output decode; a slot always runs its full count before any change.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    onehot_n = onehot;
    idx_n    = scan_idx;
    wrap_n   = 1'b0;
    case (state)
      IDLE: begin
        if (mode) begin
          state_n  = SCAN;
          onehot_n = 16'h0001;
          idx_n    = 4'd0;
          cnt_n    = CNT_RELOAD;
        end else if (in_valid) begin
          state_n  = HOLD;
          onehot_n = 16'h0001 << binary;
          cnt_n    = CNT_RELOAD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n  = IDLE;
          onehot_n = '0;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      SCAN: begin
        if (cnt == '0) begin
          if (mode) begin
            idx_n    = idx_inc;
            onehot_n = 16'h0001 << idx_inc;
            cnt_n    = CNT_RELOAD;
            wrap_n   = (scan_idx == 4'd15);
          end else begin
            state_n  = IDLE;
            onehot_n = '0;
            idx_n    = 4'd0;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        onehot_n = '0;
        idx_n    = 4'd0;
        cnt_n    = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_onehot_decoder_scan.sv
module tb_onehot_decoder_scan;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  binary;
  logic [15:0] onehot;
  logic        busy;
  logic [3:0]  scan_idx;
  logic        scan_wrap;

  int checks   = 0;
  int failures = 0;

  onehot_decoder_scan #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .binary    (binary),
    .onehot    (onehot),
    .busy      (busy),
    .scan_idx  (scan_idx),
    .scan_wrap (scan_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference 16-to-4 encoder; returns 31 for a pattern that is not one-hot.
  function automatic logic [31:0] enc(input logic [15:0] v);
    logic [31:0] r;
    int n;
    r = 32'd31;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        r = i;
        n++;
      end
    end
    if (n != 1) r = 32'd31;
    return r;
  endfunction

  logic [15:0] b2b_exp [9];
  int          sidx;

  initial begin
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; binary = 4'h0;
    #23;
    check("rst_onehot", onehot, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_idx", scan_idx, 0);
    check("rst_wrap", scan_wrap, 0);
    check("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    // Single direct decode of 0xA.
    binary = 4'hA; in_valid = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check("a_onehot", onehot, 16'h0400);
      check("a_busy", busy, 1);
      check("a_ready", in_ready, 0);
      in_valid = 1'b0;
      step();
    end
    check("a_clr_onehot", onehot, 16'h0000);
    check("a_clr_busy", busy, 0);
    check("a_clr_ready", in_ready, 1);

    // Back-to-back with in_valid held high.
    b2b_exp = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000,
                16'h8000, 16'h8000, 16'h8000, 16'h8000};
    binary = 4'h0; in_valid = 1'b1;
    step();
    binary = 4'hF;
    for (int i = 0; i < 9; i++) begin
      check("b2b_onehot", onehot, b2b_exp[i]);
      if (i == 8) in_valid = 1'b0;
      step();
    end
    check("b2b_end", onehot, 16'h0000);

    // Sweep every code and round-trip through the encoder.
    for (int c = 0; c < 16; c++) begin
      binary = 4'(c); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("sweep_onehot", onehot, 32'd1 << c);
      check("sweep_enc", enc(onehot), c);
      for (int k = 0; k < 4; k++) step();
    end
    check("sweep_idle", onehot, 16'h0000);

    // Scan for a full sweep plus part of the next, dropping mode midway through slot 5.
    mode = 1'b1;
    #1;
    check("scan_ready_low", in_ready, 0);
    step();
    for (int c = 0; c < 88; c++) begin
      sidx = (c / 4) % 16;
      check("scan_idx", scan_idx, sidx);
      check("scan_onehot", onehot, 32'd1 << sidx);
      check("scan_wrap", scan_wrap, (c == 64) ? 1 : 0);
      check("scan_busy", busy, 1);
      if (c == 85) mode = 1'b0;
      step();
    end
    check("exit_onehot", onehot, 16'h0000);
    check("exit_idx", scan_idx, 0);
    check("exit_busy", busy, 0);
    check("exit_ready", in_ready, 1);

    // Async reset mid-HOLD.
    binary = 4'h7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("mh_onehot", onehot, 16'h0080);
    #1 rst_n = 1'b0;
    #1;
    check("mh_rst_onehot", onehot, 16'h0000);
    check("mh_rst_busy", busy, 0);
    #1 rst_n = 1'b1;
    step();

    // Async reset mid-SCAN, past index 0.
    mode = 1'b1;
    for (int k = 0; k < 7; k++) step();
    check("ms_idx", scan_idx, 1);
    check("ms_onehot", onehot, 16'h0002);
    #1 rst_n = 1'b0;
    #1;
    check("ms_rst_onehot", onehot, 16'h0000);
    check("ms_rst_idx", scan_idx, 0);
    check("ms_rst_busy", busy, 0);
    check("ms_rst_wrap", scan_wrap, 0);
    mode = 1'b0;
    #1 rst_n = 1'b1;
    step();

    // Normal accept after reset release.
    binary = 4'h3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("post_onehot", onehot, 16'h0008);
    check("post_busy", busy, 1);
    for (int k = 0; k < 4; k++) step();
    check("post_clr", onehot, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
